spi_master_param: RTL and testbench
===================================

SPI_MASTER_PARAM -- requirements
Module: spi_master_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per transfer (>=2).
REQ-002 SHALL have parameter NUM_SLAVES, default 3, number of chip-select lines (>=1).
REQ-003 SHALL have parameter CLK_DIV, default 2, clk cycles per SCLK half-period (>=1).
REQ-004 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port start  input  1  transfer request, sampled only in IDLE.
REQ-007 SHALL have port slaveSelect  input  max(1,$clog2(NUM_SLAVES))  target slave index.
REQ-008 SHALL have port masterDataToSend  input  DATA_WIDTH  transmit word.
REQ-009 SHALL have port cpol  input  1  SCLK idle level, latched at start.
REQ-010 SHALL have port cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge; latched at start.
REQ-011 SHALL have port lsbFirst  input  1  1 = LSB shifted first, 0 = MSB first; latched at start.
REQ-012 SHALL have port MISO  input  1  serial data from slave.
REQ-013 SHALL have port masterDataReceived  output  DATA_WIDTH  last completed received word.
REQ-014 SHALL have port SCLK  output  1  serial clock, registered.
REQ-015 SHALL have port CS  output  NUM_SLAVES  active-low chip selects; CS[i] low selects slave i.
REQ-016 SHALL have port MOSI  output  1  serial data to slave, registered.
REQ-017 SHALL have port busy  output  1  high from cycle after start accepted until done.
REQ-018 SHALL have port done  output  1  one-cycle pulse at transfer completion.

Function
REQ-019 SHALL implement states IDLE, SETUP, TRANSFER, HOLD; transitions IDLE->SETUP on accepted start, SETUP->TRANSFER after CLK_DIV cycles, TRANSFER->HOLD after 2*DATA_WIDTH half-periods, HOLD->IDLE after CLK_DIV cycles.
REQ-020 SHALL accept start only in IDLE and only when slaveSelect < NUM_SLAVES; otherwise start is ignored with no output change.
REQ-021 SHALL, on acceptance, latch masterDataToSend, slaveSelect, cpol, cpha, lsbFirst; later input changes do not affect the transfer.
REQ-022 SHALL drive CS[slaveSelect] low (others high) and busy high from the edge accepting start through HOLD.
REQ-023 SHALL hold SCLK at latched cpol in IDLE, SETUP, HOLD; toggle every CLK_DIV cycles in TRANSFER, giving exactly DATA_WIDTH full SCLK periods.
REQ-024 SHALL, when cpha=0, present first bit on MOSI at SETUP entry, sample MISO on each leading SCLK edge, update MOSI on each trailing edge except the last.
REQ-025 SHALL, when cpha=1, update MOSI on each leading SCLK edge (first bit at first leading edge), sample MISO on each trailing edge.
REQ-026 SHALL shift out bit order per latched lsbFirst and assemble received bits in the same order so a loopback returns the transmitted word.
REQ-027 SHALL, at the edge leaving HOLD, drive all CS high, busy low, done high for one cycle, and update masterDataReceived with the assembled word.
REQ-028 SHALL have start-accept-to-done latency of exactly (2*DATA_WIDTH+2)*CLK_DIV clk cycles.
REQ-029 SHALL hold masterDataReceived stable between done pulses.
REQ-030 SHALL accept a start asserted in the done cycle (IDLE), giving back-to-back transfers with CS high for at least one cycle between them.
REQ-031 SHALL keep MOSI at its last value outside transfers.

Reset
REQ-032 SHALL, when reset is low at a clock edge, force IDLE, CS all ones, SCLK 0, MOSI 0, busy 0, done 0, masterDataReceived 0, latched cpol 0, counters 0.
REQ-033 SHALL abort any transfer on reset without a done pulse; reset overrides start in the same cycle.

Verification
REQ-034 SHALL cover mode 0, MSB-first, DATA_WIDTH=8, CLK_DIV=2, send 0xA5 to slave 1, slave returns 0x3C -> CS=3'b101, MOSI 1,0,1,0,0,1,0,1, masterDataReceived=0x3C, done 36 cycles after start.
REQ-035 SHALL cover mode 3 (cpol=1,cpha=1), LSB-first, send 0x81 to slave 2 -> SCLK idles 1, CS=3'b011, MOSI 1,0,0,0,0,0,0,1 on leading edges, loopback returns 0x81.
REQ-036 SHALL cover slaveSelect=3 with NUM_SLAVES=3 -> CS stays 3'b111, busy stays 0, no done.
REQ-037 SHALL cover start re-pulsed mid-transfer with new data 0xFF -> ignored, original word completes, single done.
REQ-038 SHALL cover reset low at bit 4 of a transfer -> next cycle CS=3'b111, SCLK=0, busy=0, masterDataReceived=0, no done.
REQ-039 SHALL cover back-to-back start in done cycle -> second transfer completes, CS high for >=1 cycle between transfers.

Source files
------------

// File: rtl/spi_master_param.sv
// Parameterised SPI master: modes 0-3, MSB/LSB first, N active-low chip selects.
// Ports: clk, reset(sync, active-low), start/slaveSelect/masterDataToSend/cpol/cpha/lsbFirst request,
//        MISO in; SCLK, MOSI, CS[NUM_SLAVES] serial side; busy, done, masterDataReceived status.
module spi_master_param #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SLAVES = 3,
  parameter int CLK_DIV    = 2,
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [SW-1:0]         slaveSelect,
  input  logic [DATA_WIDTH-1:0] masterDataToSend,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  lsbFirst,
  input  logic                  MISO,
  output logic [DATA_WIDTH-1:0] masterDataReceived,
  output logic                  SCLK,
  output logic [NUM_SLAVES-1:0] CS,
  output logic                  MOSI,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HW = $clog2(2 * DATA_WIDTH);
  localparam int IW = HW - 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(2 * DATA_WIDTH - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic [SW:0]   SEL_LIM   = (SW + 1)'(NUM_SLAVES);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [CW-1:0]         div_q;
  logic [HW-1:0]         half_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic                  cpol_q;
  logic                  cpha_q;
  logic                  lsb_q;

  logic                  sel_ok;
  logic                  accept;
  logic                  tick;
  logic                  step;
  logic                  lead;
  logic                  trail;
  logic                  last_half;
  logic                  sample;
  logic [IW-1:0]         k;
  logic [IW-1:0]         slot;

  // Bit k of the word in transmit order.
  function automatic logic pick(
    input logic [DATA_WIDTH-1:0] w,
    input logic                  lsb,
    input logic [IW-1:0]         idx
  );
    pick = lsb ? w[idx] : w[BIT_LAST - idx];
  endfunction

  assign sel_ok    = {1'b0, slaveSelect} < SEL_LIM;
  assign accept    = (state_q == IDLE) && start && sel_ok;
  assign tick      = (div_q == DIV_LAST);
  assign step      = (state_q == TRANSFER) && tick;
  // Even half-periods end on a leading edge, odd ones on a trailing edge.
  assign lead      = step && !half_q[0];
  assign trail     = step && half_q[0];
  assign last_half = (half_q == HALF_LAST);
  assign k         = half_q[HW-1:1];
  assign slot      = lsb_q ? k : BIT_LAST - k;
  assign sample    = cpha_q ? trail : lead;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = SETUP;
      SETUP:    if (tick) state_d = TRANSFER;
      TRANSFER: if (tick && last_half) state_d = HOLD;
      HOLD:     if (tick) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      div_q              <= '0;
      half_q             <= '0;
      tx_q               <= '0;
      rx_q               <= '0;
      cpol_q             <= 1'b0;
      cpha_q             <= 1'b0;
      lsb_q              <= 1'b0;
      masterDataReceived <= '0;
      SCLK               <= 1'b0;
      CS                 <= '1;
      MOSI               <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      done <= 1'b0;

      if (state_q == IDLE) begin
        div_q <= '0;
      end else begin
        div_q <= tick ? '0 : div_q + CW'(1);
      end

      if (state_q != TRANSFER) begin
        half_q <= '0;
      end else if (tick) begin
        half_q <= last_half ? '0 : half_q + HW'(1);
      end

      if (accept) begin
        tx_q   <= masterDataToSend;
        rx_q   <= '0;
        cpol_q <= cpol;
        cpha_q <= cpha;
        lsb_q  <= lsbFirst;
        SCLK   <= cpol;
        CS     <= ~(NUM_SLAVES'(1) << slaveSelect);
        busy   <= 1'b1;
        // Mode with cpha=0 needs bit 0 on the wire before the first edge.
        if (!cpha) begin
          MOSI <= pick(masterDataToSend, lsbFirst, '0);
        end
      end else if (state_q != TRANSFER) begin
        SCLK <= cpol_q;
      end

      if (step) begin
        SCLK <= ~SCLK;
      end

      if (sample) begin
        rx_q[slot] <= MISO;
      end

      if (lead && cpha_q) begin
        MOSI <= pick(tx_q, lsb_q, k);
      end

      // The final trailing edge has no next bit to present.
      if (trail && !cpha_q && !last_half) begin
        MOSI <= pick(tx_q, lsb_q, k + IW'(1));
      end

      if (state_q == HOLD && tick) begin
        CS                 <= '1;
        busy               <= 1'b0;
        done               <= 1'b1;
        masterDataReceived <= rx_q;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: vector table, slave model, done-driven scoreboard.
// Ports: none; drives every DUT port, prints one summary line.
module tb_spi_master_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] slaveSelect;
  logic [7:0] masterDataToSend;
  logic       cpol;
  logic       cpha;
  logic       lsbFirst;
  logic       MISO;
  logic [7:0] masterDataReceived;
  logic       SCLK;
  logic [2:0] CS;
  logic       MOSI;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  spi_master_param #(
    .DATA_WIDTH(8),
    .NUM_SLAVES(3),
    .CLK_DIV(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .slaveSelect(slaveSelect),
    .masterDataToSend(masterDataToSend),
    .cpol(cpol),
    .cpha(cpha),
    .lsbFirst(lsbFirst),
    .MISO(MISO),
    .masterDataReceived(masterDataReceived),
    .SCLK(SCLK),
    .CS(CS),
    .MOSI(MOSI),
    .busy(busy),
    .done(done)
  );

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] sel;
    logic       pol;
    logic       pha;
    logic       lsb;
    logic       loop;
    logic [7:0] sw;
    logic [7:0] exp_rx;
    logic [2:0] exp_cs;
    logic [7:0] exp_seq;
  } vec_t;

  typedef struct packed {
    logic [7:0] rx;
    logic [7:0] seq;
  } exp_t;

  localparam int LAT = 36;

  vec_t tab [6];
  exp_t sb [$];

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic       m_pol = 1'b0;
  logic       m_pha = 1'b0;
  logic       s_lsb = 1'b0;
  logic       loop = 1'b0;
  logic [7:0] s_word = 8'h00;
  logic       sbit = 1'b0;
  int         sidx = 0;
  logic       sclk_prev = 1'b0;
  logic [2:0] cs_prev = 3'b111;
  logic [7:0] cap = 8'h00;
  int         ncap = 0;
  logic       lead;

  assign MISO = loop ? MOSI : sbit;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic bitof(input int i);
    bitof = s_lsb ? s_word[i] : s_word[7 - i];
  endfunction

  // Scoreboard pop on done, slave shifter, MOSI capture on sampling edges.
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rx_word", 32'(masterDataReceived), 32'(e.rx));
        chk("mosi_bits", 32'(cap), 32'(e.seq));
        chk("mosi_count", ncap, 8);
      end
    end
    if (cs_prev === 3'b111 && CS !== 3'b111) begin
      cap = 8'h00;
      ncap = 0;
    end
    if (CS === 3'b111) begin
      sidx = 0;
      sbit = bitof(0);
    end else if (cs_prev !== 3'b111 && SCLK !== sclk_prev) begin
      lead = (SCLK != m_pol);
      if (lead != m_pha) begin
        cap = {cap[6:0], MOSI};
        ncap++;
      end
      if (lead && m_pha && sidx < 8) sbit = bitof(sidx);
      if (!lead) begin
        sidx++;
        if (!m_pha && sidx < 8) sbit = bitof(sidx);
      end
    end
    sclk_prev = SCLK;
    cs_prev = CS;
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic go(input vec_t v, input bit push);
    exp_t e;
    masterDataToSend = v.data;
    slaveSelect = v.sel;
    cpol = v.pol;
    cpha = v.pha;
    lsbFirst = v.lsb;
    m_pol = v.pol;
    m_pha = v.pha;
    s_lsb = v.lsb;
    loop = v.loop;
    s_word = v.sw;
    start = 1'b1;
    if (push) begin
      e.rx = v.exp_rx;
      e.seq = v.exp_seq;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("cs_active", 32'(CS), 32'(v.exp_cs));
    chk("busy_high", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int c0, input logic pol);
    int cyc;
    cyc = c0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("latency", cyc, LAT);
    chk("cs_release", 32'(CS), 32'd7);
    chk("busy_low", 32'(busy), 32'd0);
    chk("sclk_idle", 32'(SCLK), 32'(pol));
  endtask

  initial begin
    int dc;
    tab[0] = '{8'hA5, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h3C, 3'b101, 8'b10100101};
    tab[1] = '{8'h81, 2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h81, 3'b011, 8'b10000001};
    tab[2] = '{8'h3C, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 8'hC9, 8'hC9, 3'b110, 8'b00111100};
    tab[3] = '{8'h96, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h5A, 3'b011, 8'b01101001};
    tab[4] = '{8'h37, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h37, 3'b110, 8'b11101100};
    tab[5] = '{8'h00, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 3'b101, 8'b00000000};

    reset = 1'b0;
    start = 1'b0;
    slaveSelect = 2'd0;
    masterDataToSend = 8'h00;
    cpol = 1'b0;
    cpha = 1'b0;
    lsbFirst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", 32'(CS), 32'd7);
    chk("rst_sclk", 32'(SCLK), 32'd0);
    chk("rst_mosi", 32'(MOSI), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rx", 32'(masterDataReceived), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      go(tab[i], 1'b1);
      wait_done(0, tab[i].pol);
      @(posedge clk);
      #1;
      chk("done_pulse", 32'(done), 32'd0);
    end

    // Out-of-range slave index is ignored.
    dc = done_cnt;
    slaveSelect = 2'd3;
    masterDataToSend = 8'h55;
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (10) @(posedge clk);
      #1;
      chk("badsel_cs", 32'(CS), 32'd7);
      chk("badsel_busy", 32'(busy), 32'd0);
    end
    start = 1'b0;
    chk("badsel_nodone", done_cnt, dc);

    // Re-pulsed start with different settings mid-transfer.
    dc = done_cnt;
    go(tab[0], 1'b1);
    repeat (8) @(posedge clk);
    #1;
    masterDataToSend = 8'hFF;
    slaveSelect = 2'd0;
    cpol = 1'b1;
    cpha = 1'b1;
    lsbFirst = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("restart_cs", 32'(CS), 32'd5);
    wait_done(9, 1'b0);
    repeat (40) @(posedge clk);
    #1;
    chk("restart_one_done", done_cnt, dc + 1);

    // Reset in the middle of bit 4.
    dc = done_cnt;
    go(tab[0], 1'b0);
    repeat (19) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_cs", 32'(CS), 32'd7);
    chk("abort_sclk", 32'(SCLK), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_rx", 32'(masterDataReceived), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    slaveSelect = 2'd1;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_over_start_busy", 32'(busy), 32'd0);
    chk("rst_over_start_cs", 32'(CS), 32'd7);
    start = 1'b0;
    reset = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("abort_nodone", done_cnt, dc);

    // Back-to-back: second start issued in the done cycle.
    dc = done_cnt;
    go(tab[0], 1'b1);
    wait_done(0, 1'b0);
    go(tab[2], 1'b1);
    wait_done(0, 1'b0);
    @(posedge clk);
    #1;
    chk("b2b_done_pulse", 32'(done), 32'd0);
    chk("b2b_two_done", done_cnt, dc + 2);

    repeat (5) @(posedge clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
